// File: rtl/memory_write_controller.sv
// memory_write_controller
//   Takes one DATA_W-bit result plus a base word address and stores it as
//   WORDS consecutive WORD_W-bit words in a word-addressed RAM, low word first.
//   All state advances only on CLK edges qualified by the CLK_MEM strobe.
//
// Ports
//   CLK         system clock (posedge)
//   RESET       asynchronous active-high reset
//   CLK_MEM     memory-rate enable; qualifies every state update
//   ENABLE      write request, sampled in IDLE only
//   ADDRESS     base word address of the request
//   DATA        result to store; DATA[WORD_W-1:0] is written first
//   BUSY        request in flight (WRITE or DONE)
//   HANDSHAKE   completion, high in DONE only
//   WeMem       RAM write enable, (state==WRITE) & CLK_MEM
//   AddressMem  RAM word address, base + idx during WRITE, else 0
//   WriteMem    RAM write data, current word during WRITE, else 0
module memory_write_controller #(
  parameter int DATA_W = 48,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLK_MEM,
  input  logic              ENABLE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] DATA,
  output logic              BUSY,
  output logic              HANDSHAKE,
  output logic              WeMem,
  output logic [ADDR_W-1:0] AddressMem,
  output logic [WORD_W-1:0] WriteMem
);

  // Word count follows the data/word widths; it is never set on its own.
  localparam int WORDS = DATA_W / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SLOTS = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic [DATA_W-1:0]   data_reg, data_next;

  // Word select table. The index register is a power of two wide, so any
  // slot beyond the last real word reads as zero instead of out of range.
  logic [WORD_W-1:0] word_slot [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi < WORDS) begin : g_used
        assign word_slot[gi] = data_reg[gi*WORD_W +: WORD_W];
      end else begin : g_unused
        assign word_slot[gi] = '0;
      end
    end
  endgenerate

  // State register: updates only on edges where CLK_MEM is high.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      base_reg  <= '0;
      data_reg  <= '0;
    end else if (CLK_MEM) begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      base_reg  <= base_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    base_next  = base_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (ENABLE) begin
          base_next  = ADDRESS;
          data_next  = DATA;
          idx_next   = '0;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // The RAM commits the current word on this same edge.
        if (idx_reg == LAST_IDX) begin
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode straight from the state so reset clears them at once.
  logic in_write;
  assign in_write   = (state_reg == WRITE);
  assign BUSY       = (state_reg == WRITE) || (state_reg == DONE);
  assign HANDSHAKE  = (state_reg == DONE);
  assign WeMem      = in_write & CLK_MEM;
  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign AddressMem = in_write ? (base_reg + ADDR_W'(idx_reg)) : '0;
  assign WriteMem   = in_write ? word_slot[idx_reg] : '0;

endmodule

// File: tb/tb_memory_write_controller.sv
module tb_memory_write_controller;

  logic        CLK;
  logic        RESET;
  logic        CLK_MEM;
  logic        ENABLE;
  logic [31:0] ADDRESS;
  logic [47:0] DATA;
  logic        BUSY;
  logic        HANDSHAKE;
  logic        WeMem;
  logic [31:0] AddressMem;
  logic [15:0] WriteMem;

  memory_write_controller #(.DATA_W(48), .WORD_W(16), .ADDR_W(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CLK_MEM    (CLK_MEM),
    .ENABLE     (ENABLE),
    .ADDRESS    (ADDRESS),
    .DATA       (DATA),
    .BUSY       (BUSY),
    .HANDSHAKE  (HANDSHAKE),
    .WeMem      (WeMem),
    .AddressMem (AddressMem),
    .WriteMem   (WriteMem)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;

  // CLK_MEM driver: always 1, or one cycle in four when div_mode is set.
  bit div_mode = 1'b0;
  initial begin
    int ncyc;
    ncyc = 0;
    CLK_MEM = 1'b1;
    forever begin
      @(negedge CLK);
      CLK_MEM = div_mode ? ((ncyc % 4) == 0) : 1'b1;
      ncyc++;
    end
  end

  // RAM-side write log, sampled just before each rising edge.
  logic [31:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];
  int          cyc = 0;
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      cyc++;
      if (WeMem === 1'b1) begin
        log_addr.push_back(AddressMem);
        log_data.push_back(WriteMem);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  // Raise ENABLE with a request and wait for acceptance (bounded).
  task automatic req(input logic [31:0] a, input logic [47:0] d, input bit drop_enable);
    @(negedge CLK);
    ENABLE  = 1'b1;
    ADDRESS = a;
    DATA    = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (BUSY) break;
    end
    check("accept", BUSY, 1'b1);
    if (drop_enable) ENABLE = 1'b0;
  endtask

  // Wait for BUSY to fall, counting cycles with HANDSHAKE high.
  task automatic wait_done(output int hs);
    hs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (HANDSHAKE) hs++;
      if (!BUSY) break;
    end
    check("done_busy_low", BUSY, 1'b0);
  endtask

  task automatic check_three(input int ofs,
                             input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                             input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    check("write_count", 64'(log_addr.size() >= ofs + 3), 64'd1);
    if (log_addr.size() >= ofs + 3) begin
      check("addr0", log_addr[ofs],     a0);
      check("addr1", log_addr[ofs + 1], a1);
      check("addr2", log_addr[ofs + 2], a2);
      check("data0", log_data[ofs],     w0);
      check("data1", log_data[ofs + 1], w1);
      check("data2", log_data[ofs + 2], w2);
    end
  endtask

  typedef struct packed {
    logic [31:0] addr;
    logic [47:0] data;
    logic [31:0] ea0, ea1, ea2;
    logic [15:0] ew0, ew1, ew2;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int hs;
    vecs[0] = '{32'h0000_0100, 48'hAAAA_BBBB_CCCC,
                32'h0000_0100, 32'h0000_0101, 32'h0000_0102,
                16'hCCCC, 16'hBBBB, 16'hAAAA};
    vecs[1] = '{32'hFFFF_FFFF, 48'h0003_0002_0001,
                32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001,
                16'h0001, 16'h0002, 16'h0003};
    vecs[2] = '{32'h7FFF_FFFE, 48'h1234_5678_9ABC,
                32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000,
                16'h9ABC, 16'h5678, 16'h1234};

    RESET   = 1'b1;
    ENABLE  = 1'b0;
    ADDRESS = '0;
    DATA    = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", BUSY, 1'b0);
    check("rst_hs",   HANDSHAKE, 1'b0);
    check("rst_we",   WeMem, 1'b0);
    check("rst_addr", AddressMem, 32'h0);
    check("rst_wdata", WriteMem, 16'h0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_no_enable", BUSY, 1'b0);

    // Table-driven single requests at full memory rate.
    for (int k = 0; k < 3; k++) begin
      clear_log();
      req(vecs[k].addr, vecs[k].data, 1'b1);
      wait_done(hs);
      $display("vec %0d: addr=0x%08h data=0x%012h writes=%0d hs_cycles=%0d",
               k, vecs[k].addr, vecs[k].data, log_addr.size(), hs);
      check_three(0, vecs[k].ea0, vecs[k].ea1, vecs[k].ea2,
                  vecs[k].ew0, vecs[k].ew1, vecs[k].ew2);
      if (log_cyc.size() >= 3) begin
        check("spacing01", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
        check("spacing12", 64'(log_cyc[2] - log_cyc[1]), 64'd1);
      end
      check("hs_len", 64'(hs), 64'd1);
      check("idle_addr", AddressMem, 32'h0);
      check("idle_wdata", WriteMem, 16'h0);
    end

    // CLK_MEM one cycle in four: writes 4 CLK apart, HANDSHAKE 4 CLK long.
    div_mode = 1'b1;
    clear_log();
    req(32'h100, 48'hAAAA_BBBB_CCCC, 1'b1);
    wait_done(hs);
    $display("div4: writes=%0d hs_cycles=%0d", log_addr.size(), hs);
    check_three(0, 32'h100, 32'h101, 32'h102, 16'hCCCC, 16'hBBBB, 16'hAAAA);
    check("div_pulses", 64'(log_addr.size()), 64'd3);
    if (log_cyc.size() >= 3) begin
      check("div_spacing01", 64'(log_cyc[1] - log_cyc[0]), 64'd4);
      check("div_spacing12", 64'(log_cyc[2] - log_cyc[1]), 64'd4);
    end
    check("div_hs_len", 64'(hs), 64'd4);
    div_mode = 1'b0;
    repeat (4) @(negedge CLK);

    // Request arriving while busy is dropped.
    clear_log();
    req(32'h100, 48'hAAAA_BBBB_CCCC, 1'b1);
    @(negedge CLK);
    ENABLE  = 1'b1;
    ADDRESS = 32'h200;
    DATA    = 48'h1111_1111_1111;
    wait_done(hs);
    ENABLE = 1'b0;
    repeat (4) @(negedge CLK);
    $display("drop: writes=%0d hs_cycles=%0d", log_addr.size(), hs);
    check_three(0, 32'h100, 32'h101, 32'h102, 16'hCCCC, 16'hBBBB, 16'hAAAA);
    check("drop_count", 64'(log_addr.size()), 64'd3);
    check("drop_idle", BUSY, 1'b0);

    // Reset mid-request, then a normal request.
    clear_log();
    req(32'h100, 48'hAAAA_BBBB_CCCC, 1'b1);
    @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    check("mid_rst_we",   WeMem, 1'b0);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_hs",   HANDSHAKE, 1'b0);
    check("mid_rst_addr", AddressMem, 32'h0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    $display("mid reset: partial writes=%0d", log_addr.size());
    check("partial_count", 64'(log_addr.size()), 64'd1);
    if (log_addr.size() >= 1) begin
      check("partial_addr", log_addr[0], 32'h100);
      check("partial_data", log_data[0], 16'hCCCC);
    end
    check("post_rst_idle", BUSY, 1'b0);
    clear_log();
    req(32'h300, 48'h0F0F_0E0E_0D0D, 1'b1);
    wait_done(hs);
    $display("post reset: addr=0x300 writes=%0d hs_cycles=%0d", log_addr.size(), hs);
    check_three(0, 32'h300, 32'h301, 32'h302, 16'h0D0D, 16'h0E0E, 16'h0F0F);
    check("post_rst_hs", 64'(hs), 64'd1);

    // ENABLE held high: back-to-back requests with a 5-edge period.
    clear_log();
    req(32'h400, 48'h3333_2222_1111, 1'b0);
    ADDRESS = 32'h500;
    DATA    = 48'h6666_5555_4444;
    wait_done(hs);
    @(negedge CLK);
    check("b2b_second_accept", BUSY, 1'b1);
    ENABLE = 1'b0;
    wait_done(hs);
    repeat (3) @(negedge CLK);
    $display("back-to-back: writes=%0d", log_addr.size());
    check("b2b_count", 64'(log_addr.size()), 64'd6);
    check_three(0, 32'h400, 32'h401, 32'h402, 16'h1111, 16'h2222, 16'h3333);
    check_three(3, 32'h500, 32'h501, 32'h502, 16'h4444, 16'h5555, 16'h6666);
    if (log_cyc.size() >= 4) begin
      check("b2b_period", 64'(log_cyc[3] - log_cyc[0]), 64'd5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
